mac_stream: RTL and testbench

// - Parametrised signed multiply-accumulate engine for one neuron:

---
 rtl/mac_pkg.sv | 34 +++
 rtl/mac_mul_stage.sv | 33 +++
 rtl/mac_stream.sv | 134 +++++++++++++
 tb/tb_mac_stream.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the streaming multiply-accumulate neuron engine:
// default widths, FSM state encoding and the output saturation helper.
package mac_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ACC_W     = 24;
    localparam int DEF_MAX_TERMS = 400;
    localparam int DEF_CNT_W     = 9;
    localparam int DEF_OUT_W     = 16;
    localparam int DEF_SHIFT     = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_state_e;

    // Clips a sign-extended value into the signed range of an out_w-bit result.
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] s,
                                                    input int out_w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 1));
        if (s > max_v) begin
            return max_v;
        end else if (s < min_v) begin
            return min_v;
        end
        return s;
    endfunction

endpackage

// File: rtl/mac_mul_stage.sv
// Registered signed DATA_W x DATA_W multiplier with a valid flag; kept separate
// so it can later be swapped for a multi-cycle or shift-add implementation.
module mac_mul_stage import mac_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_fire,
    input  logic signed [DATA_W-1:0]   x_in,
    input  logic signed [DATA_W-1:0]   w_in,
    output logic signed [2*DATA_W-1:0] prod,
    output logic                       prod_valid
);

    logic signed [2*DATA_W-1:0] x_ext;
    logic signed [2*DATA_W-1:0] w_ext;

    assign x_ext = {{DATA_W{x_in[DATA_W-1]}}, x_in};
    assign w_ext = {{DATA_W{w_in[DATA_W-1]}}, w_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod       <= '0;
            prod_valid <= 1'b0;
        end else begin
            prod_valid <= in_fire;
            if (in_fire) begin
                prod <= x_ext * w_ext;
            end
        end
    end

endmodule

// File: rtl/mac_stream.sv
// Streaming signed MAC for one neuron: accumulates N x*w pairs onto a bias,
// then returns a scaled, saturated result over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; pipeline empty
// RUN   | accepting pairs until N have been transferred
// DRAIN | waiting for the multiplier and accumulator stages to empty
// DONE  | result presented, held until out_ready
module mac_stream import mac_pkg::*; #(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int MAX_TERMS = DEF_MAX_TERMS,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int SHIFT     = DEF_SHIFT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CNT_W-1:0]         num_terms,
    input  logic signed [ACC_W-1:0]  bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] w_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         result,
    output logic                     overflow,
    output logic                     busy
);

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_TERMS);

    mac_state_e state;
    mac_state_e state_next;

    logic [CNT_W-1:0]           cnt;
    logic [CNT_W-1:0]           cnt_inc;
    logic [CNT_W-1:0]           n_reg;
    logic [CNT_W-1:0]           n_clamped;
    logic                       in_fire;
    logic                       start_ok;
    logic signed [2*DATA_W-1:0] prod;
    logic                       prod_valid;
    logic                       acc_valid;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_shifted;
    logic signed [63:0]         s_wide;
    logic signed [63:0]         sat_wide;
    logic                       sat_ovf;

    assign in_fire   = in_valid && in_ready;
    assign start_ok  = (state == IDLE) && start;
    assign cnt_inc   = cnt + CNT_W'(1);
    assign n_clamped = (num_terms > MAX_N) ? MAX_N : num_terms;
    assign busy      = (state != IDLE);

    mac_mul_stage #(.DATA_W(DATA_W)) u_mul (
        .clk        (clk),
        .reset      (reset),
        .in_fire    (in_fire),
        .x_in       (x_in),
        .w_in       (w_in),
        .prod       (prod),
        .prod_valid (prod_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN waits until both the product and the accumulate stage are idle,
    // which places out_valid three edges after the final transfer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (n_clamped == '0) ? DRAIN : RUN;
            RUN:     if (in_fire && (cnt_inc == n_reg)) state_next = DRAIN;
            DRAIN:   if (!prod_valid && !acc_valid) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready  <= 1'b0;
            acc_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            n_reg     <= '0;
        end else begin
            in_ready  <= (state_next == RUN);
            acc_valid <= prod_valid;
            if (start_ok) begin
                acc   <= bias;
                cnt   <= '0;
                n_reg <= n_clamped;
            end else begin
                if (prod_valid) begin
                    acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
                end
                if (in_fire) begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

    assign acc_shifted = acc >>> SHIFT;
    assign s_wide      = {{(64-ACC_W){acc_shifted[ACC_W-1]}}, acc_shifted};
    assign sat_wide    = sat_clip(s_wide, OUT_W);
    assign sat_ovf     = (sat_wide != s_wide);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= (state_next == DONE);
            if ((state == DRAIN) && (state_next == DONE)) begin
                result   <= sat_wide[OUT_W-1:0];
                overflow <= sat_ovf;
            end
        end
    end

endmodule

// File: tb/tb_mac_stream.sv
// Directed and randomized checks of mac_stream against an arithmetic reference,
// using a SHIFT=0 instance and a SHIFT=2 instance fed from the same stream.
module tb_mac_stream;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;
    localparam int CNT_W  = 9;
    localparam int OUT_W  = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic [CNT_W-1:0]         num_terms;
    logic signed [ACC_W-1:0]  bias;
    logic                     in_valid;
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] w_in;
    logic                     out_ready;

    logic             a_in_ready, a_out_valid, a_overflow, a_busy;
    logic [OUT_W-1:0] a_result;
    logic             b_in_ready, b_out_valid, b_overflow, b_busy;
    logic [OUT_W-1:0] b_result;

    int     n_vec = 0;
    int     n_err = 0;
    int     xs[400];
    int     ws[400];
    longint exp_r0, exp_r1;
    longint exp_o0, exp_o1;

    always #5 clk = ~clk;

    mac_stream u_dut (
        .clk(clk), .reset(reset), .start(start), .num_terms(num_terms), .bias(bias),
        .in_valid(in_valid), .in_ready(a_in_ready), .x_in(x_in), .w_in(w_in),
        .out_valid(a_out_valid), .out_ready(out_ready), .result(a_result),
        .overflow(a_overflow), .busy(a_busy)
    );

    mac_stream #(.SHIFT(2)) u_dut_s2 (
        .clk(clk), .reset(reset), .start(start), .num_terms(num_terms), .bias(bias),
        .in_valid(in_valid), .in_ready(b_in_ready), .x_in(x_in), .w_in(w_in),
        .out_valid(b_out_valid), .out_ready(out_ready), .result(b_result),
        .overflow(b_overflow), .busy(b_busy)
    );

    task automatic check(input string tag, input string what,
                         input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, what, obs, expv);
        end
    endtask

    function automatic longint clamp_out(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Exact sum, wrapped to the accumulator width, then scaled and clamped.
    task automatic compute_expect(input int n, input longint b);
        longint sum;
        longint wa;
        sum = b;
        for (int i = 0; i < n; i++) sum += longint'(xs[i]) * longint'(ws[i]);
        wa = sum & 64'sh0000_0000_00FF_FFFF;
        if (wa > 64'sd8388607) wa -= 64'sd16777216;
        exp_r0 = clamp_out(wa);
        exp_o0 = (exp_r0 != wa) ? 1 : 0;
        exp_r1 = clamp_out(wa >>> 2);
        exp_o1 = (exp_r1 != (wa >>> 2)) ? 1 : 0;
    endtask

    // mode: 0 continuous valid, 1 valid every other cycle, 2 random bubbles
    task automatic run_job(input string tag, input int req_n, input int eff_n, input longint b,
                           input int mode, input int hold, input bit chk_lat, input bit poke);
        int idx;
        int guard;
        int lat;
        logic fire;
        compute_expect(eff_n, b);
        @(posedge clk); #1;
        start = 1'b1; num_terms = CNT_W'(req_n); bias = ACC_W'(b);
        @(posedge clk); #1;
        start = 1'b0; num_terms = CNT_W'($urandom); bias = ACC_W'($urandom);
        check(tag, "busy_after_start", 64'(a_busy), 64'(1));
        if (eff_n == 0) check(tag, "in_ready_n0", 64'(a_in_ready), 64'(0));
        idx = 0;
        guard = 0;
        while (idx < eff_n && guard < 4000) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (guard % 2 == 0);
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            x_in = DATA_W'(xs[idx]);
            w_in = DATA_W'(ws[idx]);
            if (poke && idx == eff_n / 2) begin
                start = 1'b1; num_terms = CNT_W'(3); bias = ACC_W'(999);
            end
            fire = in_valid && a_in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
            if (fire) idx++;
        end
        in_valid = 1'b0;
        check(tag, "pairs_accepted", 64'(idx), 64'(eff_n));
        if (eff_n > 0) check(tag, "in_ready_after_last", 64'(a_in_ready), 64'(0));
        lat = 0;
        while (!a_out_valid && lat < 60) begin
            if (eff_n == 0) check(tag, "in_ready_n0_wait", 64'(a_in_ready), 64'(0));
            @(posedge clk); #1;
            lat++;
        end
        check(tag, "out_valid", 64'(a_out_valid), 64'(1));
        if (chk_lat) check(tag, "latency", 64'(lat), 64'(3));
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check(tag, "held_valid", 64'(a_out_valid), 64'(1));
            check(tag, "held_result", 64'($signed(a_result)), exp_r0);
        end
        check(tag, "result_s0", 64'($signed(a_result)), exp_r0);
        check(tag, "overflow_s0", 64'(a_overflow), exp_o0);
        check(tag, "out_valid_s2", 64'(b_out_valid), 64'(1));
        check(tag, "result_s2", 64'($signed(b_result)), exp_r1);
        check(tag, "overflow_s2", 64'(b_overflow), exp_o1);
        out_ready = 1'b1;
        if (poke) begin
            start = 1'b1; num_terms = CNT_W'(1); bias = ACC_W'(0);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        start = 1'b0;
        check(tag, "out_valid_drop", 64'(a_out_valid), 64'(0));
        check(tag, "busy_idle", 64'(a_busy), 64'(0));
        check(tag, "in_ready_idle", 64'(a_in_ready), 64'(0));
        if (hold > 0) begin
            @(posedge clk); #1;
            check(tag, "single_beat", 64'(a_out_valid), 64'(0));
        end
    endtask

    initial begin
        logic signed [ACC_W-1:0] rb;
        int n;
        reset = 1'b1; start = 1'b0; num_terms = '0; bias = '0;
        in_valid = 1'b0; x_in = '0; w_in = '0; out_ready = 1'b0;
        #1;
        check("reset", "in_ready", 64'(a_in_ready), 64'(0));
        check("reset", "out_valid", 64'(a_out_valid), 64'(0));
        check("reset", "busy", 64'(a_busy), 64'(0));
        check("reset", "result", 64'(a_result), 64'(0));
        check("reset", "overflow", 64'(a_overflow), 64'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Abort after 5 of 10 pairs, then a fresh job must be unaffected.
        for (int i = 0; i < 10; i++) begin xs[i] = i + 1; ws[i] = 1; end
        @(posedge clk); #1;
        start = 1'b1; num_terms = CNT_W'(10); bias = '0;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            x_in = DATA_W'(xs[k]); w_in = DATA_W'(ws[k]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("abort", "in_ready", 64'(a_in_ready), 64'(0));
        check("abort", "out_valid", 64'(a_out_valid), 64'(0));
        check("abort", "busy", 64'(a_busy), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("abort", "no_result", 64'(a_out_valid), 64'(0));
        end
        xs[0] = 1; ws[0] = 1; xs[1] = 1; ws[1] = 1;
        run_job("fresh_n2", 2, 2, 0, 0, 0, 1'b1, 1'b0);

        xs[0] = 3;  ws[0] = 4;
        xs[1] = -2; ws[1] = 5;
        xs[2] = 7;  ws[2] = -1;
        xs[3] = 10; ws[3] = 10;
        run_job("n4_cont", 4, 4, 0, 0, 0, 1'b1, 1'b0);
        check("n4_cont", "literal", 64'($signed(a_result)), 64'(95));
        run_job("n4_toggle", 4, 4, 0, 1, 5, 1'b1, 1'b0);
        run_job("n4_poke", 4, 4, 0, 0, 2, 1'b1, 1'b1);

        for (int i = 0; i < 400; i++) begin xs[i] = 127; ws[i] = 127; end
        run_job("sat_max", 400, 400, 0, 0, 0, 1'b1, 1'b0);
        check("sat_max", "literal", 64'($signed(a_result)), 64'(32767));
        for (int i = 0; i < 400; i++) xs[i] = -128;
        run_job("sat_min", 400, 400, 0, 0, 0, 1'b1, 1'b0);
        check("sat_min", "literal", 64'($signed(a_result)), -64'sd32768);

        run_job("n0_bias", 0, 0, -300, 0, 1, 1'b0, 1'b0);
        check("n0_bias", "literal", 64'($signed(a_result)), -64'sd300);
        xs[0] = -8; ws[0] = 8;
        run_job("n1_shift", 1, 1, 64, 0, 0, 1'b1, 1'b0);
        check("n1_shift", "literal_s2", 64'($signed(b_result)), 64'(0));

        for (int i = 0; i < 400; i++) begin
            xs[i] = int'($urandom_range(0, 255)) - 128;
            ws[i] = int'($urandom_range(0, 255)) - 128;
        end
        run_job("clamp", 511, 400, 17, 2, 0, 1'b1, 1'b0);

        for (int j = 0; j < 1000; j++) begin
            n = int'($urandom_range(0, 40));
            for (int i = 0; i < n; i++) begin
                xs[i] = int'($urandom_range(0, 255)) - 128;
                ws[i] = int'($urandom_range(0, 255)) - 128;
            end
            rb = ($urandom_range(0, 1) == 0) ? ACC_W'($urandom) : ACC_W'(int'($urandom_range(0, 4000)) - 2000);
            run_job("random", n, n, longint'(rb), 2, int'($urandom_range(0, 3)), n > 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
